// File: rtl/morse_pkg.sv
// Shared encodings for the Morse element sequencer: FSM states, element codes
// and symbol sizing.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int SYM_LEN_W = 3;

    localparam logic                 DIT       = 1'b0;
    localparam logic                 DASH      = 1'b1;
    localparam logic [SYM_LEN_W-1:0] MAX_ELEMS = SYM_LEN_W'(5);

endpackage

// File: rtl/morse_run_counter.sv
// Run-length counter for the key level: restarts at 1 when the level changes
// and otherwise counts up, holding at all-ones instead of wrapping.
module morse_run_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_element_sequencer.sv
// Times key marks and spaces, assembles dit/dash elements into symbols and
// hands them downstream through a one-deep valid/ready buffer.
module morse_element_sequencer
    import morse_pkg::*;
#(
    parameter int DASH_MIN   = 7,
    parameter int LETTER_GAP = 16,
    parameter int WORD_GAP   = 48,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_in,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [4:0]           sym_bits,
    output logic [SYM_LEN_W-1:0] sym_len,
    output logic                 word_gap,
    output logic                 err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] DASH_MIN_C    = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] LETTER_LAST_C = CNT_W'(LETTER_GAP - 1);
    localparam logic [CNT_W-1:0] WORD_LAST_C   = CNT_W'(WORD_GAP - 1);

    state_t               state;
    logic                 key_q;
    logic [CNT_W-1:0]     cnt;
    logic [4:0]           asm_bits;
    logic [SYM_LEN_W-1:0] asm_len;
    logic                 asm_ovf;
    logic                 accept;

    assign accept = sym_valid && sym_ready;

    morse_run_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk  (clk),
        .rst  (rst),
        .load (key_in ^ key_q),
        .cnt  (cnt)
    );

    // cnt holds the length of the run that ends with the previous sample, so
    // thresholds compare against one less than the count they name.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_q     <= 1'b0;
            asm_bits  <= '0;
            asm_len   <= '0;
            asm_ovf   <= 1'b0;
            sym_valid <= 1'b0;
            sym_bits  <= '0;
            sym_len   <= '0;
            word_gap  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            key_q    <= key_in;
            word_gap <= 1'b0;
            err      <= 1'b0;
            // NOTE: a letter load further down overrides this clear, since the
            // last non-blocking assignment in the block wins (no bubble).
            if (accept) sym_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (key_in) begin
                        state <= MARK;
                        busy  <= 1'b1;
                    end
                end
                MARK: begin
                    if (!key_in) begin
                        if (asm_len == MAX_ELEMS) begin
                            asm_ovf <= 1'b1;
                        end else begin
                            asm_bits[asm_len] <= (cnt >= DASH_MIN_C) ? DASH : DIT;
                            asm_len           <= asm_len + 1'b1;
                        end
                        state <= SPACE;
                    end
                end
                SPACE: begin
                    if (key_in) begin
                        state <= MARK;
                    end else if (cnt == LETTER_LAST_C) begin
                        if (!asm_ovf && (!sym_valid || sym_ready)) begin
                            sym_valid <= 1'b1;
                            sym_bits  <= asm_bits;
                            sym_len   <= asm_len;
                        end else begin
                            err <= 1'b1;
                        end
                        asm_bits <= '0;
                        asm_len  <= '0;
                        asm_ovf  <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (key_in) begin
                        state <= MARK;
                    end else if (cnt == WORD_LAST_C) begin
                        word_gap <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/morse_element_sequencer.md
# morse_element_sequencer

Sequencer between the synchronized Morse key input (btnR path) and the letter decode/display datapath in morse_code_interpreter_top. It times key marks and spaces in clock cycles, classifies each mark as dit or dash, assembles up to five elements into a symbol, and hands completed symbols downstream through a one-deep valid/ready buffer. It also flags word gaps and malformed letters.

## Interface
- DASH_MIN, 7: mark of at least this many cycles is a dash; shorter is a dit.
- LETTER_GAP, 16: consecutive low cycles that complete a letter.
- WORD_GAP, 48: consecutive low cycles, counted from the last falling edge, that signal a word gap.
- CNT_W, 8: run-counter width. Requires WORD_GAP < 2^CNT_W − 1.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- key_in  in  1  Morse key level; already synchronous to clk.
- sym_valid  out  1  output buffer holds a symbol.
- sym_ready  in  1  downstream accepts the symbol.
- sym_bits  out  5  element i in bit i, first element in bit 0; 1 = dash, 0 = dit; unused bits 0.
- sym_len  out  3  element count, 1..5.
- word_gap  out  1  one-cycle pulse.
- err  out  1  one-cycle pulse on a dropped letter.
- busy  out  1  high when FSM is not IDLE.

## Operation
- key_in is sampled on every rising clk edge.
- One run counter, cnt:
  - Loads 1 on every key_in transition.
  - Otherwise increments, saturating at all-ones.
- FSM states: IDLE, MARK, SPACE, GAP.
- IDLE:
  - key_in=1 goes to MARK with cnt=1.
  - key_in=0 stays.
- MARK:
  - key_in=1 increments cnt.
  - key_in=0 classifies the element: dash if cnt ≥ DASH_MIN, else dit. Then go to SPACE with cnt=1.
  - Classified element is written to asm_bits[asm_len] and asm_len increments.
  - If asm_len is already 5, the element is discarded and the sticky asm_ovf is set.
- SPACE:
  - key_in=1 goes to MARK with cnt=1.
  - The sample on which cnt would reach LETTER_GAP completes the letter, then go to GAP. cnt keeps counting.
- Letter completion:
  - asm_ovf=0 and buffer free, or being accepted in the same cycle: load sym_bits/sym_len and set sym_valid.
  - asm_ovf=1: discard the letter and pulse err.
  - Buffer full and not accepted in that cycle: discard the letter and pulse err. The held symbol is unchanged.
  - In every case asm_bits, asm_len and asm_ovf clear.
- GAP:
  - key_in=1 goes to MARK with cnt=1 (new letter).
  - The sample on which cnt reaches WORD_GAP pulses word_gap, then go to IDLE.
- Output buffer:
  - Transfer occurs when sym_valid && sym_ready at a rising edge; sym_valid drops the next cycle unless a new load happens in the same cycle.
  - sym_bits/sym_len are stable while sym_valid is high.
  - Fully decoupled from the FSM; the FSM never stalls.
- Reset, asynchronous, at any time including mid-mark or mid-handshake:
  - State goes to IDLE; cnt and assembly registers clear.
  - All outputs go to 0: sym_valid, sym_bits, sym_len, word_gap, err, busy.
  - The in-flight symbol is lost.

## Timing
- A mark of N high samples is classified on the edge that samples the first low.
- asm_bits updates on that same edge.
- sym_valid rises on the edge that takes the LETTER_GAP-th consecutive low sample, i.e. is visible the following cycle.
- word_gap and err are registered one-cycle pulses, coincident with the causing edge.
- busy is registered from state.
- Simultaneous letter completion and acceptance: the new symbol loads and sym_valid stays high with no bubble.
- A space shorter than LETTER_GAP is an intra-letter gap.
- A glitch of a single high cycle counts as a dit.
- cnt saturation does not wrap. A long hold stays classified as a dash.

## Structure
- Shared morse_pkg holds:
  - FSM state encoding.
  - Element encodings DIT=0, DASH=1.
  - MAX_ELEMS=5.
  - SYM_LEN_W=3.
- One sub-module, morse_run_counter: saturating CNT_W counter with synchronous load-1 and async reset.
- FSM, assembly register and output buffer live in morse_element_sequencer.

## Test plan
- Reset 1 cycle, then 4 × (6 cycles high, 2 low), then 20 low, sym_ready=1 → sym_len=4, sym_bits=5'b00000 ("H"), one sym_valid cycle, no err.
- 8 cycles high, then 20 low → sym_len=1, sym_bits=5'b00001 ("T").
- Marks of 6 and 7 cycles, then 20 low → sym_bits=5'b00010, sym_len=2 (boundary at DASH_MIN).
- "T", then 48 low cycles → word_gap pulses exactly once on the 48th low sample; busy=0 afterwards; a 47-cycle gap gives no pulse.
- Six dits, then 20 low → no sym_valid, a single err pulse; the next letter decodes normally.
- sym_ready=0 while two letters complete → the first is held unchanged and err pulses at the second; assert rst mid-mark → all outputs 0 immediately, and a following "H" decodes correctly.
